wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 104 ++++++++++
 tb/tb_wb_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter in front of a register file.
// Three requesters (0=ALU, 1=LSU, 2=CSR) compete for one write port. The
// grant is combinational. The winning write is registered for one cycle and
// is exposed to two source-operand bypass comparators.
//
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   req_valid[2:0]         per-requester writeback request
//   req_addr[14:0]         5-bit destination per requester, i at [5i+4:5i]
//   req_data[95:0]         32-bit data per requester, i at [32i+31:32i]
//   req_ready[2:0]         one-hot grant (transfer = valid & ready)
//   flush                  kills grants and the next-cycle write
//   w_en, w_addr, w_data   registered register-file write port
//   r_addr1, r_addr2       source addresses for bypass compare
//   fwd_hit1/2, fwd_data1/2  bypass hit and data
module wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req_valid,
  input  logic [14:0] req_addr,
  input  logic [95:0] req_data,
  output logic [2:0]  req_ready,
  input  logic        flush,
  output logic        w_en,
  output logic [4:0]  w_addr,
  output logic [31:0] w_data,
  input  logic [4:0]  r_addr1,
  input  logic [4:0]  r_addr2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2
);

  logic [1:0]  rr_ptr;
  logic [1:0]  ptr_eff;
  logic        gnt_any;
  logic [1:0]  gnt_idx;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;
  int          idx;

  // Scan from the highest offset down so the lowest offset (first in
  // round-robin order) overwrites and wins. Grants are suppressed while
  // in reset or flushing.
  always_comb begin
    ptr_eff = (rr_ptr == 2'd3) ? 2'd0 : rr_ptr;
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    idx     = 0;
    for (int k = 2; k >= 0; k--) begin
      idx = (int'(ptr_eff) + k) % 3;
      if (rst_n && !flush && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = 2'(idx);
      end
    end
  end

  assign req_ready = gnt_any ? (3'b001 << gnt_idx) : 3'b000;

  always_comb begin
    sel_addr = req_addr[4:0];
    sel_data = req_data[31:0];
    case (gnt_idx)
      2'd1: begin
        sel_addr = req_addr[9:5];
        sel_data = req_data[63:32];
      end
      2'd2: begin
        sel_addr = req_addr[14:10];
        sel_data = req_data[95:64];
      end
      default: begin
        sel_addr = req_addr[4:0];
        sel_data = req_data[31:0];
      end
    endcase
  end

  // Writes to x0 are accepted (and advance the pointer) but never enable
  // the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 2'd0;
      w_en   <= 1'b0;
      w_addr <= 5'd0;
      w_data <= 32'd0;
    end else begin
      w_en <= gnt_any && (sel_addr != 5'd0);
      if (gnt_any) begin
        w_addr <= sel_addr;
        w_data <= sel_data;
        rr_ptr <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
      end
    end
  end

  assign fwd_hit1  = w_en && (w_addr == r_addr1) && (r_addr1 != 5'd0);
  assign fwd_hit2  = w_en && (w_addr == r_addr2) && (r_addr2 != 5'd0);
  assign fwd_data1 = w_data;
  assign fwd_data2 = w_data;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        flush;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [4:0]  r_addr1, r_addr2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;

  int n_tests = 0;
  int n_fail  = 0;

  wb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .flush(flush), .w_en(w_en),
    .w_addr(w_addr), .w_data(w_data), .r_addr1(r_addr1), .r_addr2(r_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1),
    .fwd_data2(fwd_data2)
  );

  always #5 clk = ~clk;

  // Reference model: pointer as an integer, pending write as plain values.
  int          m_ptr;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_gr = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int grant_of(int ptr, logic [2:0] v, logic fl, logic rn);
    int id;
    if (!rn || fl) return -1;
    for (int k = 0; k < 3; k++) begin
      id = (ptr + k) % 3;
      if (v[id]) return id;
    end
    return -1;
  endfunction

  function automatic logic [4:0] addr_of(int i);
    return req_addr[5*i +: 5];
  endfunction

  function automatic logic [31:0] data_of(int i);
    return req_data[32*i +: 32];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g;
    if (!rst_n) begin
      m_ptr = 0; m_wen = 0; m_waddr = 0; m_wdata = 0;
    end else begin
      g = grant_of(m_ptr, req_valid, flush, rst_n);
      if (g >= 0) begin
        m_ptr   = (g + 1) % 3;
        m_wen   = (addr_of(g) != 0);
        m_waddr = addr_of(g);
        m_wdata = data_of(g);
      end else begin
        m_wen = 0;
      end
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    int g;
    logic [2:0] er;
    g  = grant_of(m_ptr, req_valid, flush, rst_n);
    er = (g < 0) ? 3'b000 : 3'(1 << g);
    m_gr = g;
    chk("ready", 32'(req_ready), 32'(er));
    chk("w_en", 32'(w_en), 32'(m_wen));
    chk("w_addr", 32'(w_addr), 32'(m_waddr));
    chk("w_data", w_data, m_wdata);
    chk("fwd_hit1", 32'(fwd_hit1), 32'(m_wen && m_waddr == r_addr1 && r_addr1 != 0));
    chk("fwd_hit2", 32'(fwd_hit2), 32'(m_wen && m_waddr == r_addr2 && r_addr2 != 0));
    chk("fwd_data1", fwd_data1, m_wdata);
    chk("fwd_data2", fwd_data2, m_wdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]       = v;
    req_addr[5*i +: 5] = a;
    req_data[32*i +: 32] = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int wait1, max_wait1;
    logic tog;

    rst_n = 0; flush = 0; req_valid = 0; req_addr = 0; req_data = 0;
    r_addr1 = 0; r_addr2 = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_w_en", 32'(w_en), 0);
    chk("rst_w_data", w_data, 0);
    step();
    rst_n = 1;

    // All three valid: grants 0,1,2 in turn.
    set_req(0, 1, 5'd1, 32'hA0); set_req(1, 1, 5'd2, 32'hA1); set_req(2, 1, 5'd3, 32'hA2);
    @(negedge clk); chk("rr_g0", 32'(req_ready), 32'b001);
    step(); req_valid[0] = 0;
    @(negedge clk); chk("rr_g1", 32'(req_ready), 32'b010);
    chk("rr_wa1", 32'(w_addr), 1); chk("rr_we1", 32'(w_en), 1);
    step(); req_valid[1] = 0;
    @(negedge clk); chk("rr_g2", 32'(req_ready), 32'b100);
    chk("rr_wa2", 32'(w_addr), 2); chk("rr_wd2", w_data, 32'hA1);
    step(); req_valid[2] = 0;
    @(negedge clk); chk("rr_wa3", 32'(w_addr), 3); chk("rr_we3", 32'(w_en), 1);
    step();
    @(negedge clk); chk("idle_we", 32'(w_en), 0); chk("idle_wa_hold", 32'(w_addr), 3);
    step();

    // x0 write: accepted, no enable, pointer advances.
    set_req(0, 1, 5'd0, 32'hDEADBEEF);
    @(negedge clk); chk("x0_ready", 32'(req_ready), 32'b001);
    step();
    set_req(0, 1, 5'd7, 32'h77); set_req(1, 1, 5'd9, 32'h99);
    @(negedge clk); chk("x0_we", 32'(w_en), 0); chk("x0_wd", w_data, 32'hDEADBEEF);
    chk("x0_ptr_adv", 32'(req_ready), 32'b010);
    step(); req_valid[1] = 0;
    @(negedge clk); chk("x0_next", 32'(req_ready), 32'b001); chk("x0_wa9", 32'(w_addr), 9);
    step(); req_valid[0] = 0;

    // Bypass.
    set_req(1, 1, 5'd5, 32'h12345678);
    @(negedge clk); chk("byp_ready", 32'(req_ready), 32'b010);
    step(); req_valid[1] = 0; r_addr1 = 5; r_addr2 = 0;
    @(negedge clk); chk("byp_hit1", 32'(fwd_hit1), 1); chk("byp_d1", fwd_data1, 32'h12345678);
    chk("byp_hit2", 32'(fwd_hit2), 0);
    step(); r_addr1 = 0;

    // Flush.
    flush = 1; set_req(1, 1, 5'd6, 32'h66);
    @(negedge clk); chk("fl_ready", 32'(req_ready), 0);
    step(); flush = 0;
    @(negedge clk); chk("fl_we", 32'(w_en), 0); chk("fl_after", 32'(req_ready), 32'b010);
    step(); req_valid[1] = 0;
    @(negedge clk); chk("fl_wa", 32'(w_addr), 6); chk("fl_wen", 32'(w_en), 1);
    step();

    // Reset right after a grant.
    set_req(0, 1, 5'd4, 32'h44);
    @(negedge clk); chk("rs_ready", 32'(req_ready), 32'b001);
    step();
    chk("rs_we_pre", 32'(w_en), 1);
    set_req(0, 1, 5'd10, 32'h10); set_req(1, 1, 5'd11, 32'h11); set_req(2, 1, 5'd12, 32'h12);
    r_addr1 = 4;
    #1 rst_n = 0;
    #1;
    chk("rs_we_async", 32'(w_en), 0); chk("rs_wa", 32'(w_addr), 0);
    chk("rs_ready0", 32'(req_ready), 0); chk("rs_hit1", 32'(fwd_hit1), 0);
    step(); step();
    rst_n = 1;
    @(negedge clk); chk("rs_first_g0", 32'(req_ready), 32'b001);
    step(); req_valid = 0; r_addr1 = 0;
    step();

    // Requester 1 always valid, requester 0 toggling.
    wait1 = 0; max_wait1 = 0; tog = 0;
    set_req(1, 1, 5'd13, 32'h1300);
    for (int c = 0; c < 40; c++) begin
      if (!req_valid[0] || m_gr == 0) begin
        tog = ~tog;
        set_req(0, tog, 5'(14 + c % 8), 32'(c));
      end
      @(negedge clk);
      if (m_gr == 1) wait1 = 0; else wait1++;
      if (req_ready[1]) wait1 = 0;
      if (wait1 > max_wait1) max_wait1 = wait1;
      step();
      if (m_gr == 1) set_req(1, 1, 5'(c % 31 + 1), 32'(c + 100));
    end
    chk("fair_wait_le2", 32'(max_wait1 > 2), 0);
    req_valid = 0;
    step();

    // Random traffic obeying hold-until-accepted.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] || m_gr == i)
          set_req(i, ($urandom % 100) < 60, 5'($urandom_range(0, 7)), $urandom);
      end
      flush   = ($urandom % 100) < 8;
      r_addr1 = 5'($urandom_range(0, 7));
      r_addr2 = 5'($urandom_range(0, 7));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
